// File: rtl/shift_bus_master.sv
// Job-to-register-port initiator for the shifter peripheral: programs control and
// operand, restarts the engine, waits out the shift, reads the result back.
module shift_bus_master #(
  parameter int unsigned WAIT_EXTRA = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        job_valid,
  output logic        job_ready,
  input  logic [15:0] job_value,
  input  logic        job_dir,
  input  logic [14:0] job_amount,
  output logic        cs,
  output logic        we,
  output logic [1:0]  reg_sel,
  output logic [15:0] bus_wdata,
  input  logic [15:0] bus_rdata,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [15:0] res_data,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE, WR_CTRL, WR_OPND, START, WAIT, RD, RESP
  } state_e;

  localparam logic [4:0] WAIT_EXTRA_W = 5'(WAIT_EXTRA);

  state_e      state_q, state_d;
  logic [15:0] value_q, value_d;
  logic        dir_q, dir_d;
  logic [14:0] amount_q, amount_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [15:0] res_q, res_d;
  logic [4:0]  clamp;

  // Shift counts of 16 or more are saturated to 15 before sizing the wait.
  always_comb clamp = (amount_q >= 15'd16) ? 5'd15 : {1'b0, amount_q[3:0]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      value_q  <= '0;
      dir_q    <= 1'b0;
      amount_q <= '0;
      cnt_q    <= '0;
      res_q    <= '0;
    end else begin
      state_q  <= state_d;
      value_q  <= value_d;
      dir_q    <= dir_d;
      amount_q <= amount_d;
      cnt_q    <= cnt_d;
      res_q    <= res_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    value_d   = value_q;
    dir_d     = dir_q;
    amount_d  = amount_q;
    cnt_d     = cnt_q;
    res_d     = res_q;
    cs        = 1'b0;
    we        = 1'b0;
    reg_sel   = 2'b00;
    bus_wdata = '0;
    job_ready = 1'b0;
    res_valid = 1'b0;
    busy      = 1'b1;
    unique case (state_q)
      IDLE: begin
        job_ready = 1'b1;
        busy      = 1'b0;
        if (job_valid) begin
          value_d  = job_value;
          dir_d    = job_dir;
          amount_d = job_amount;
          state_d  = WR_CTRL;
        end
      end
      WR_CTRL: begin
        cs        = 1'b1;
        we        = 1'b1;
        reg_sel   = 2'b00;
        bus_wdata = {dir_q, amount_q};
        state_d   = WR_OPND;
      end
      WR_OPND: begin
        cs        = 1'b1;
        we        = 1'b1;
        reg_sel   = 2'b01;
        bus_wdata = value_q;
        state_d   = START;
      end
      START: begin
        cs      = 1'b1;
        reg_sel = 2'b11;
        cnt_d   = clamp + WAIT_EXTRA_W;
        state_d = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q - 5'd1;
        if (cnt_q == 5'd1) state_d = RD;
      end
      RD: begin
        cs      = 1'b1;
        reg_sel = 2'b10;
        res_d   = bus_rdata;
        state_d = RESP;
      end
      RESP: begin
        res_valid = 1'b1;
        if (res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign res_data = res_q;

endmodule

// File: tb/tb_shift_bus_master.sv
// Bench for shift_bus_master: a small shifter-peripheral model answers reads, and
// expected results are queued at job acceptance and compared at the result handshake.
module tb_shift_bus_master;

  localparam int WX = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        job_valid = 1'b0;
  logic        job_ready;
  logic [15:0] job_value = '0;
  logic        job_dir = 1'b0;
  logic [14:0] job_amount = '0;
  logic        cs, we;
  logic [1:0]  reg_sel;
  logic [15:0] bus_wdata;
  logic [15:0] bus_rdata;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [15:0] res_data;
  logic        busy;

  shift_bus_master #(.WAIT_EXTRA(WX)) dut (
    .clk(clk), .reset(reset),
    .job_valid(job_valid), .job_ready(job_ready), .job_value(job_value),
    .job_dir(job_dir), .job_amount(job_amount),
    .cs(cs), .we(we), .reg_sel(reg_sel), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Peripheral model: control/operand registers, result = operand shifted by ctrl[3:0].
  logic [15:0] p_ctrl = '0, p_opnd = '0;
  always @(posedge clk) begin
    if (cs && we && reg_sel == 2'b00) p_ctrl <= bus_wdata;
    if (cs && we && reg_sel == 2'b01) p_opnd <= bus_wdata;
  end
  always_comb begin
    bus_rdata = '0;
    case (reg_sel)
      2'b00: bus_rdata = p_ctrl;
      2'b01: bus_rdata = p_opnd;
      2'b10: bus_rdata = p_ctrl[15] ? (p_opnd >> p_ctrl[3:0]) : (p_opnd << p_ctrl[3:0]);
      default: bus_rdata = '0;
    endcase
  end

  logic [19:0] bus_word;
  assign bus_word = {cs, we, reg_sel, bus_wdata};

  int n_checks = 0;
  int n_pass = 0;
  int last_resp = -100;
  logic [15:0] sb[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  task automatic wait_ready();
    int k;
    k = 0;
    while (!job_ready && k < 64) begin
      @(negedge clk);
      k++;
    end
    if (!job_ready) check("ready_timeout", 32'(job_ready), 32'd1);
  endtask

  task automatic do_job(input logic [15:0] v, input logic d, input logic [14:0] a,
                        input int hold, input bit b2b);
    int n, t0;
    logic [15:0] exp_res, popped;
    n = ((a >= 15'd16) ? 15 : int'(a[3:0])) + WX;
    exp_res = d ? (v >> a[3:0]) : (v << a[3:0]);
    wait_ready();
    res_ready  = (hold == 0);
    job_value  = v;
    job_dir    = d;
    job_amount = a;
    job_valid  = 1'b1;
    t0 = cyc;
    if (b2b) check("b2b_accept", 32'(t0), 32'(last_resp + 1));
    sb.push_back(exp_res);
    @(negedge clk);
    job_valid  = 1'b0;
    job_value  = ~v;
    job_dir    = ~d;
    job_amount = ~a;
    check("wr_ctrl", 32'(bus_word), 32'({1'b1, 1'b1, 2'b00, d, a}));
    check("busy", 32'(busy), 32'd1);
    @(negedge clk);
    check("wr_opnd", 32'(bus_word), 32'({1'b1, 1'b1, 2'b01, v}));
    @(negedge clk);
    check("start", 32'(bus_word), 32'({1'b1, 1'b0, 2'b11, 16'h0}));
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("wait_bus", 32'({res_valid, job_ready, bus_word}), 32'd0);
    end
    @(negedge clk);
    check("rd", 32'({res_valid, bus_word}), 32'({1'b0, 1'b1, 1'b0, 2'b10, 16'h0}));
    @(negedge clk);
    check("resp_valid", 32'(res_valid), 32'd1);
    for (int i = 0; i < hold; i++) begin
      check("hold_valid", 32'(res_valid), 32'd1);
      check("hold_ready", 32'({job_ready, bus_word}), 32'd0);
      check("hold_data", 32'(res_data), 32'(exp_res));
      job_valid  = 1'b1;
      job_value  = v ^ 16'h5A5A;
      job_amount = 15'd1;
      @(negedge clk);
    end
    job_valid = 1'b0;
    res_ready = 1'b1;
    check("hs_valid", 32'(res_valid), 32'd1);
    if (sb.size() == 0) check("sb_empty", 32'd0, 32'd1);
    else begin
      popped = sb.pop_front();
      check("res_data", 32'(res_data), 32'(popped));
    end
    last_resp = cyc;
    @(negedge clk);
    check("idle_after", 32'({job_ready, busy, res_valid}), 32'b100);
  endtask

  task automatic reset_during(input int k, input logic [14:0] a);
    int bad;
    wait_ready();
    job_value  = 16'hBEEF;
    job_dir    = 1'b0;
    job_amount = a;
    job_valid  = 1'b1;
    @(negedge clk);
    job_valid = 1'b0;
    repeat (k - 1) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("rst_bus", 32'(bus_word), 32'd0);
    check("rst_flags", 32'({job_ready, busy, res_valid}), 32'b100);
    check("rst_rdata", 32'(res_data), 32'd0);
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus_word != 0 || res_valid) bad++;
    end
    reset = 1'b1;
    repeat (25) begin
      @(negedge clk);
      if (bus_word != 0 || res_valid || !job_ready) bad++;
    end
    check("rst_quiet", 32'(bad), 32'd0);
  endtask

  initial begin
    #1;
    check("por_bus", 32'(bus_word), 32'd0);
    check("por_flags", 32'({job_ready, busy, res_valid}), 32'b100);
    check("por_rdata", 32'(res_data), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    do_job(16'h00F0, 1'b0, 15'd4,     0, 1'b0);
    do_job(16'hA5C3, 1'b1, 15'h0100,  0, 1'b1);
    do_job(16'h1234, 1'b0, 15'd0,     0, 1'b1);
    do_job(16'h8001, 1'b1, 15'd3,     5, 1'b0);
    do_job(16'h0F0F, 1'b0, 15'd7,     0, 1'b1);
    reset_during(2, 15'd9);
    do_job(16'h3C3C, 1'b1, 15'd2,     0, 1'b0);
    reset_during(6, 15'd9);
    do_job(16'hFFFF, 1'b1, 15'd15,    0, 1'b0);
    do_job(16'h0003, 1'b0, 15'd16,    0, 1'b1);
    do_job(16'h4001, 1'b0, 15'h7FFF,  2, 1'b0);
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
